// File: rtl/axil_led_regs.sv
// AXI4-Lite register block: LED output, two scratch registers and a
// read-only status word holding write/read transaction counts.
//
// Write FSM
//   state      | meaning
//   W_IDLE     | nothing held, AW and W both accepted
//   W_HAVE_AW  | address held, waiting for write data
//   W_HAVE_W   | write data held, waiting for address
//   W_COMMIT   | both held, register update on the next edge
//   W_RESP     | bvalid high, waiting for bready
module axil_led_regs #(
  parameter int ADDR_WIDTH = 12,
  parameter int LED_WIDTH  = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [LED_WIDTH-1:0]  leds_o
);

  typedef enum logic [2:0] {
    W_IDLE    = 3'd0,
    W_HAVE_AW = 3'd1,
    W_HAVE_W  = 3'd2,
    W_COMMIT  = 3'd3,
    W_RESP    = 3'd4
  } wr_state_t;

  wr_state_t            wr_state_q, wr_state_d;
  logic [1:0]           aw_idx_q, aw_idx_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           wstrb_q, wstrb_d;
  logic [1:0]           bresp_q, bresp_d;
  logic [31:0]          data_q, scratch0_q, scratch1_q;
  logic [15:0]          wr_cnt_q, rd_cnt_q;
  logic                 rvalid_q;
  logic [31:0]          rdata_q, rd_mux;
  logic [LED_WIDTH-1:0] leds_q;
  logic                 aw_hs, w_hs, ar_hs, r_hs, commit;

  // Only address bits [3:2] select a register; the rest are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

  assign s_axi_awready = (wr_state_q == W_IDLE) || (wr_state_q == W_HAVE_W);
  assign s_axi_wready  = (wr_state_q == W_IDLE) || (wr_state_q == W_HAVE_AW);
  assign s_axi_bvalid  = (wr_state_q == W_RESP);
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = ~rvalid_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;
  assign leds_o        = leds_q;

  assign aw_hs  = s_axi_awvalid & s_axi_awready;
  assign w_hs   = s_axi_wvalid & s_axi_wready;
  assign ar_hs  = s_axi_arvalid & s_axi_arready;
  assign r_hs   = rvalid_q & s_axi_rready;
  assign commit = (wr_state_q == W_COMMIT);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  // Write FSM next state, AW/W holding registers and response code.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    if (aw_hs) aw_idx_d = s_axi_awaddr[3:2];
    if (w_hs) begin
      wdata_d = s_axi_wdata;
      wstrb_d = s_axi_wstrb;
    end
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) wr_state_d = W_COMMIT;
        else if (aw_hs)    wr_state_d = W_HAVE_AW;
        else if (w_hs)     wr_state_d = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)  wr_state_d = W_COMMIT;
      W_HAVE_W:  if (aw_hs) wr_state_d = W_COMMIT;
      W_COMMIT: begin
        wr_state_d = W_RESP;
        bresp_d    = (aw_idx_q == 2'd3) ? 2'b10 : 2'b00;
      end
      W_RESP:    if (s_axi_bready) wr_state_d = W_IDLE;
      default:   wr_state_d = W_IDLE;
    endcase
  end

  // Write FSM state and holding registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state_q <= W_IDLE;
      aw_idx_q   <= 2'd0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
      bresp_q    <= 2'b00;
    end else begin
      wr_state_q <= wr_state_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
    end
  end

  // Register file update, write counter and the one-cycle-late LED copy.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      data_q     <= 32'd0;
      scratch0_q <= 32'd0;
      scratch1_q <= 32'd0;
      wr_cnt_q   <= 16'd0;
      leds_q     <= '0;
    end else begin
      if (commit) begin
        case (aw_idx_q)
          2'd0:    data_q     <= merge_bytes(data_q, wdata_q, wstrb_q);
          2'd1:    scratch0_q <= merge_bytes(scratch0_q, wdata_q, wstrb_q);
          2'd2:    scratch1_q <= merge_bytes(scratch1_q, wdata_q, wstrb_q);
          default: ;
        endcase
        if (aw_idx_q != 2'd3) wr_cnt_q <= wr_cnt_q + 16'd1;
      end
      leds_q <= data_q[LED_WIDTH-1:0];
    end
  end

  // Read source select; values are the pre-edge contents.
  always_comb begin
    rd_mux = 32'd0;
    case (s_axi_araddr[3:2])
      2'd0:    rd_mux = data_q;
      2'd1:    rd_mux = scratch0_q;
      2'd2:    rd_mux = scratch1_q;
      default: rd_mux = {rd_cnt_q, wr_cnt_q};
    endcase
  end

  // Read channel: single outstanding read, counter bumps on R handshake.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      rd_cnt_q <= 16'd0;
    end else if (r_hs) begin
      rvalid_q <= 1'b0;
      rd_cnt_q <= rd_cnt_q + 16'd1;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_mux;
    end
  end

endmodule

// File: tb/tb_axil_led_regs.sv
// Bench for axil_led_regs: directed register-map checks followed by
// randomized concurrent write/read traffic, all compared every cycle
// against a transaction-level model of the register block.
module tb_axil_led_regs;
  localparam int AW = 12;
  localparam int LW = 4;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic [AW-1:0] s_axi_awaddr = '0;
  logic          s_axi_awvalid = 1'b0;
  logic          s_axi_awready;
  logic [31:0]   s_axi_wdata = '0;
  logic [3:0]    s_axi_wstrb = '0;
  logic          s_axi_wvalid = 1'b0;
  logic          s_axi_wready;
  logic [1:0]    s_axi_bresp;
  logic          s_axi_bvalid;
  logic          s_axi_bready = 1'b0;
  logic [AW-1:0] s_axi_araddr = '0;
  logic          s_axi_arvalid = 1'b0;
  logic          s_axi_arready;
  logic [31:0]   s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          s_axi_rvalid;
  logic          s_axi_rready = 1'b0;
  logic [LW-1:0] leds_o;

  always #5 ACLK = ~ACLK;

  axil_led_regs #(.ADDR_WIDTH(AW), .LED_WIDTH(LW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .leds_o(leds_o)
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: register array, two counters, and
  // flags for which halves of a write are held and which responses wait.
  logic [31:0]   m_reg [0:2];
  logic [15:0]   m_wcnt, m_rcnt;
  bit            m_aw_held, m_w_held, m_bvalid, m_rvalid;
  logic [1:0]    m_aw_idx, m_bresp;
  logic [31:0]   m_wdata, m_rdata;
  logic [3:0]    m_wstrb;
  logic [LW-1:0] m_leds;

  function automatic logic [31:0] m_read(input logic [1:0] idx);
    if (idx == 2'd3) return {m_rcnt, m_wcnt};
    return m_reg[idx];
  endfunction

  task automatic model_edge();
    logic [31:0] mask;
    if (ARESET) begin
      for (int i = 0; i < 3; i++) m_reg[i] = 32'd0;
      m_wcnt = 0; m_rcnt = 0;
      m_aw_held = 0; m_w_held = 0; m_bvalid = 0; m_rvalid = 0;
      m_aw_idx = 0; m_bresp = 0; m_wdata = 0; m_rdata = 0; m_wstrb = 0;
      m_leds = 0;
      return;
    end
    m_leds = m_reg[0][LW-1:0];
    if (m_rvalid) begin
      if (s_axi_rready) begin
        m_rvalid = 0;
        m_rcnt = m_rcnt + 16'd1;
      end
    end else if (s_axi_arvalid) begin
      m_rdata  = m_read(s_axi_araddr[3:2]);
      m_rvalid = 1;
    end
    if (m_bvalid) begin
      if (s_axi_bready) m_bvalid = 0;
    end else if (m_aw_held && m_w_held) begin
      if (m_aw_idx == 2'd3) begin
        m_bresp = 2'b10;
      end else begin
        mask = 32'd0;
        for (int i = 0; i < 4; i++)
          if (m_wstrb[i]) mask = mask | (32'hFF << (8 * i));
        m_reg[m_aw_idx] = (m_reg[m_aw_idx] & ~mask) | (m_wdata & mask);
        m_wcnt  = m_wcnt + 16'd1;
        m_bresp = 2'b00;
      end
      m_aw_held = 0;
      m_w_held  = 0;
      m_bvalid  = 1;
    end else begin
      if (!m_aw_held && s_axi_awvalid) begin
        m_aw_held = 1;
        m_aw_idx  = s_axi_awaddr[3:2];
      end
      if (!m_w_held && s_axi_wvalid) begin
        m_w_held = 1;
        m_wdata  = s_axi_wdata;
        m_wstrb  = s_axi_wstrb;
      end
    end
  endtask

  // Advance the model on every active edge.
  always @(posedge ACLK) model_edge();

  // Compare DUT outputs against the model away from the active edge.
  always @(negedge ACLK) begin
    if (chk_en) begin
      check("awready", 32'(s_axi_awready), 32'(!m_aw_held && !m_bvalid));
      check("wready",  32'(s_axi_wready),  32'(!m_w_held && !m_bvalid));
      check("arready", 32'(s_axi_arready), 32'(!m_rvalid));
      check("bvalid",  32'(s_axi_bvalid),  32'(m_bvalid));
      check("rvalid",  32'(s_axi_rvalid),  32'(m_rvalid));
      check("leds",    32'(leds_o),        32'(m_leds));
      if (m_bvalid) check("bresp", 32'(s_axi_bresp), 32'(m_bresp));
      if (m_rvalid) begin
        check("rdata", s_axi_rdata, m_rdata);
        check("rresp", 32'(s_axi_rresp), 32'd0);
      end
    end
  end

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_dly,
                          output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, b_done = 0;
    bit aw_hs, w_hs, b_hs;
    int t = 0, since_b = 0;
    logic [1:0] r_tmp;
    resp = 2'b11;
    s_axi_awaddr = a;
    s_axi_wdata  = d;
    s_axi_wstrb  = s;
    while (!b_done && t < 200) begin
      s_axi_awvalid = !aw_done && (t >= aw_dly);
      s_axi_wvalid  = !w_done && (t >= w_dly);
      s_axi_bready  = s_axi_bvalid && (since_b >= b_dly);
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      b_hs  = s_axi_bvalid && s_axi_bready;
      r_tmp = s_axi_bresp;
      if (s_axi_bvalid) since_b++;
      @(posedge ACLK); #1;
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      if (b_hs) begin
        b_done = 1;
        resp = r_tmp;
      end
      t++;
    end
    s_axi_awvalid = 0;
    s_axi_wvalid  = 0;
    s_axi_bready  = 0;
    if (!b_done) check("wr_timeout", 32'(b_done), 32'd1);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int ar_dly, input int r_dly,
                         output logic [31:0] data, output logic [1:0] resp);
    bit ar_done = 0, r_done = 0;
    bit ar_hs, r_hs;
    int t = 0, since_r = 0;
    logic [31:0] d_tmp;
    logic [1:0] r_tmp;
    data = 32'hX;
    resp = 2'b11;
    s_axi_araddr = a;
    while (!r_done && t < 200) begin
      s_axi_arvalid = !ar_done && (t >= ar_dly);
      s_axi_rready  = s_axi_rvalid && (since_r >= r_dly);
      ar_hs = s_axi_arvalid && s_axi_arready;
      r_hs  = s_axi_rvalid && s_axi_rready;
      d_tmp = s_axi_rdata;
      r_tmp = s_axi_rresp;
      if (s_axi_rvalid) since_r++;
      @(posedge ACLK); #1;
      if (ar_hs) ar_done = 1;
      if (r_hs) begin
        r_done = 1;
        data = d_tmp;
        resp = r_tmp;
      end
      t++;
    end
    s_axi_arvalid = 0;
    s_axi_rready  = 0;
    if (!r_done) check("rd_timeout", 32'(r_done), 32'd1);
  endtask

  initial begin
    logic [1:0]  br, rr;
    logic [31:0] rd;

    @(posedge ACLK); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    repeat (5) @(posedge ACLK);
    #1;
    check("idle_awready", 32'(s_axi_awready), 32'd1);
    check("idle_wready",  32'(s_axi_wready),  32'd1);
    check("idle_arready", 32'(s_axi_arready), 32'd1);
    check("idle_bvalid",  32'(s_axi_bvalid),  32'd0);
    check("idle_rvalid",  32'(s_axi_rvalid),  32'd0);
    check("idle_leds",    32'(leds_o),        32'd0);
    do_read(12'hC, 0, 0, rd, rr);
    check("status_after_reset", rd, 32'h0000_0000);

    do_write(12'h0, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, br);
    check("data_bresp", 32'(br), 32'd0);
    repeat (2) @(posedge ACLK);
    #1 check("leds_all_on", 32'(leds_o), 32'hF);
    do_read(12'h0, 0, 0, rd, rr);
    check("data_readback", rd, 32'hFFFF_FFFF);

    do_write(12'h4, 32'hDEAD_BEEF, 4'hF, 3, 0, 0, br);
    check("w_first_bresp", 32'(br), 32'd0);
    do_read(12'h4, 0, 0, rd, rr);
    check("scratch0_readback", rd, 32'hDEAD_BEEF);
    check("scratch0_rresp", 32'(rr), 32'd0);

    do_write(12'h8, 32'h0000_0000, 4'hF, 0, 0, 0, br);
    do_write(12'h8, 32'h1234_5678, 4'b0101, 0, 1, 0, br);
    do_read(12'h8, 0, 0, rd, rr);
    check("strobe_merge", rd, 32'h0034_0078);

    do_write(12'hC, 32'hAAAA_AAAA, 4'hF, 0, 0, 0, br);
    check("status_write_slverr", 32'(br), 32'b10);
    do_read(12'hC, 0, 0, rd, rr);
    check("status_counts", rd, 32'h0004_0004);

    do_write(12'h4, 32'h0102_0304, 4'hF, 0, 0, 4, br);
    check("stall_bresp", 32'(br), 32'd0);
    do_read(12'h4, 0, 4, rd, rr);
    check("stall_rdata", rd, 32'h0102_0304);

    // Abandon a write whose response is still pending.
    s_axi_awaddr  = 12'h0;
    s_axi_wdata   = 32'h0000_0005;
    s_axi_wstrb   = 4'hF;
    s_axi_awvalid = 1;
    s_axi_wvalid  = 1;
    @(posedge ACLK); #1;
    s_axi_awvalid = 0;
    s_axi_wvalid  = 0;
    for (int i = 0; i < 10 && !s_axi_bvalid; i++) begin
      @(posedge ACLK); #1;
    end
    check("pre_reset_bvalid", 32'(s_axi_bvalid), 32'd1);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    check("reset_bvalid", 32'(s_axi_bvalid), 32'd0);
    check("reset_leds",   32'(leds_o),       32'd0);
    ARESET = 1'b0;
    do_read(12'h0, 0, 0, rd, rr);
    check("reset_data", rd, 32'd0);
    do_read(12'h8, 0, 0, rd, rr);
    check("reset_scratch1", rd, 32'd0);
    do_read(12'hC, 0, 0, rd, rr);
    check("reset_status", rd, 32'h0002_0000);

    fork
      begin
        logic [1:0] wb;
        for (int i = 0; i < 60; i++) begin
          do_write(AW'($urandom), $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), wb);
          repeat ($urandom_range(0, 2)) @(posedge ACLK);
          #1;
        end
      end
      begin
        logic [31:0] rdd;
        logic [1:0]  rrr;
        for (int j = 0; j < 60; j++) begin
          do_read(AW'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), rdd, rrr);
          repeat ($urandom_range(0, 2)) @(posedge ACLK);
          #1;
        end
      end
    join

    repeat (3) @(posedge ACLK);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axil_led_regs.md
Name: axil_led_regs

Overview:
- AXI4-Lite responder (slave) for the PS GP0 master port in the zynq7000 block design.
- Decodes a 16-byte window containing four 32-bit registers: LED output, two scratch registers and a read-only status/counter register.
- Drives the board LEDs and provides write/read-back targets for PS-side VIP testbenches.
- Single clock domain. Read and write channels operate independently.

Parameters:
- ADDR_WIDTH, 12, width of awaddr/araddr. Only bits [3:2] are decoded; bits [1:0] and bits above 3 are ignored.
- LED_WIDTH, 4, number of LED outputs, driven from DATA[LED_WIDTH-1:0]. Legal range 1..32.

Ports:
- ACLK  in  1  clock
- ARESET  in  1  synchronous reset, active-high
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte enables
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_bresp  out  2  write response: 00 = OKAY, 10 = SLVERR
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_araddr  in  ADDR_WIDTH  read address
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response, always 00
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- leds_o  out  LED_WIDTH  LED drive, equal to DATA[LED_WIDTH-1:0]

Behaviour:
- Register map:
  - 0x0 DATA: R/W.
  - 0x4 SCRATCH0: R/W.
  - 0x8 SCRATCH1: R/W.
  - 0xC STATUS: RO. [15:0] = successful write count, [31:16] = read count. Both fields wrap 0xFFFF -> 0x0000.
- Reset (ARESET high at a rising edge):
  - All registers and counters go to 0.
  - awready = wready = arready = 1.
  - bvalid = rvalid = 0; bresp = rresp = 00; rdata = 0; leds_o = 0.
- Reset mid-transaction: any in-flight transaction is abandoned; no commit and no response is issued.
- Write path:
  - AW and W are captured independently into holding registers, in either order or in the same cycle.
  - awready is high when no address is held and bvalid = 0. wready is high when no data is held and bvalid = 0.
  - At the edge after both are held:
    - Commit the write, with each byte lane updated only where its wstrb bit is 1.
    - Set bvalid, with bresp = 00 (or 10 for address 0xC).
    - Clear both holding registers.
  - Write to 0xC: data discarded, bresp = SLVERR, write count unchanged.
  - Write count increments by 1 on each OKAY commit, including commits with wstrb = 0.
  - bvalid is held until the bready handshake. awready and wready re-assert the cycle after the B handshake.
  - Write FSM states: IDLE (nothing held) -> HAVE_AW or HAVE_W -> COMMIT (both held) -> RESP (bvalid = 1) -> IDLE on bready.
- Read path:
  - On the AR handshake edge: rdata is registered from the decoded register, rvalid = 1, arready = 0.
  - Latency is 1 cycle from the AR handshake to rvalid.
  - rdata and rvalid are held stable until rready. On the R handshake edge: rvalid = 0, arready = 1, and the read count increments (wrapping).
  - Maximum one outstanding read.
- Simultaneous events:
  - A read whose AR handshake occurs on the same edge as a write commit to the same register returns the old value.
  - A STATUS read returns the counts as they stood before that edge.
  - When a write commit and a read completion occur on the same edge, both counters update independently.
- leds_o is registered and changes the cycle after the DATA commit edge.

Test Plan:
- Reset, then idle 5 cycles -> all readies = 1, all valids = 0, leds_o = 0x0, STATUS read returns 0x00000000.
- Write 0xFFFFFFFF to 0x0, AW and W in the same cycle, bready = 1 -> bvalid with bresp = 00 exactly 1 cycle after the handshake, leds_o = 0xF, DATA read returns 0xFFFFFFFF.
- W presented 3 cycles before AW, data 0xDEADBEEF to 0x4 -> wready drops after the W handshake and no commit occurs until AW. A subsequent read of 0x4 returns 0xDEADBEEF with rresp = 00 and rvalid 1 cycle after arready.
- Write 0x12345678 to 0x8 with wstrb = 0b0101 over a prior value of 0 -> readback 0x00340078.
- Write 0xAAAAAAAA to 0xC -> bresp = 10. STATUS[15:0] is unchanged (the count from previous writes) and STATUS[31:16] has advanced by the reads performed.
- Hold bready = 0 for 4 cycles after a write -> bvalid and bresp stable, awready/wready stay 0 until the handshake.
- Hold rready = 0 for 4 cycles after a read -> rvalid and rdata stable, arready stays 0 until the handshake.
- Assert ARESET while bvalid = 1 -> bvalid = 0 and all registers = 0 on the next edge.
